uart_rx: RTL

//  Receive side of the UART link: 8N1 / 8E1 / 8O1 receiver, LSB first, 16x oversampled via UART_CLK_EN.

---
 rtl/uart_pkg.sv | 22 ++
 rtl/uart_rx_sync.sv | 30 +++
 rtl/uart_rx.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive path: state encoding, parity modes, frame constants.
package uart_pkg;

   typedef enum logic [3:0] {
      IDLE   = 4'd0,
      START  = 4'd1,
      DATA   = 4'd2,
      PARITY = 4'd3,
      STOP   = 4'd4
   } state_t;

   localparam int PARITY_NONE = 0;
   localparam int PARITY_EVEN = 1;
   localparam int PARITY_ODD  = 2;
   localparam int MID_TICK    = 7;
   localparam int DATA_BITS   = 8;

   function automatic logic parity_enabled(input int mode);
      return (mode == PARITY_EVEN) || (mode == PARITY_ODD);
   endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Brings the asynchronous RXD pin into the CLK domain and flags 1->0 transitions.
module uart_rx_sync (
   input  logic CLK,
   input  logic RST,
   input  logic rxd,
   output logic rxd_sync,
   output logic fall_edge
);

   logic meta_reg;
   logic sync_reg;
   logic prev_reg;

   // All three flops reset to the idle-high line level so reset never fakes an edge.
   always_ff @(posedge CLK) begin
      if (RST) begin
         meta_reg <= 1'b1;
         sync_reg <= 1'b1;
         prev_reg <= 1'b1;
      end else begin
         meta_reg <= rxd;
         sync_reg <= meta_reg;
         prev_reg <= sync_reg;
      end
   end

   assign rxd_sync  = sync_reg;
   assign fall_edge = prev_reg & ~sync_reg;

endmodule

// File: rtl/uart_rx.sv
// 8N1/8E1/8O1 UART receiver, LSB first, 16x oversampled on UART_CLK_EN.
// Optional build macro UART_RX_MAJORITY_EN: 2-of-3 vote over ticks 5,6,7 instead of a single tick-7 sample.
module uart_rx
   import uart_pkg::*;
#(
   parameter int PARITY_BIT = 0
) (
   input  logic       CLK,
   input  logic       RST,
   input  logic       UART_CLK_EN,
   input  logic       UART_RXD,
   output logic [7:0] DATA_OUT,
   output logic       DATA_VLD,
   output logic       FRAME_ERROR,
   output logic       PARITY_ERROR,
   output logic       BUSY,
   output logic [3:0] STATE
);

   localparam logic PAR_EN  = parity_enabled(PARITY_BIT);
   localparam logic PAR_ODD = (PARITY_BIT == PARITY_ODD);

   logic rxd_sync;
   logic fall_edge;

   uart_rx_sync u_sync (
      .CLK       (CLK),
      .RST       (RST),
      .rxd       (UART_RXD),
      .rxd_sync  (rxd_sync),
      .fall_edge (fall_edge)
   );

   state_t     state_reg,  state_next;
   logic [3:0] tick_reg,   tick_next;
   logic [2:0] count_reg,  count_next;
   logic [7:0] shift_reg,  shift_next;
   logic       perr_reg,   perr_next;
   logic [7:0] data_reg,   data_next;
   logic       vld_reg,    vld_next;
   logic       ferr_reg,   ferr_next;
   logic       pstb_reg,   pstb_next;

   logic mid_tick;
   logic sample;

   assign mid_tick = UART_CLK_EN && (tick_reg == 4'(MID_TICK));

`ifdef UART_RX_MAJORITY_EN
   logic s5_reg;
   logic s6_reg;

   always_ff @(posedge CLK) begin
      if (RST) begin
         s5_reg <= 1'b1;
         s6_reg <= 1'b1;
      end else if (UART_CLK_EN) begin
         if (tick_reg == 4'(MID_TICK - 2)) s5_reg <= rxd_sync;
         if (tick_reg == 4'(MID_TICK - 1)) s6_reg <= rxd_sync;
      end
   end

   assign sample = (s5_reg & s6_reg) | (s5_reg & rxd_sync) | (s6_reg & rxd_sync);
`else
   assign sample = rxd_sync;
`endif

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_reg <= IDLE;
         tick_reg  <= 4'd0;
         count_reg <= 3'd0;
         shift_reg <= 8'd0;
         perr_reg  <= 1'b0;
         data_reg  <= 8'd0;
         vld_reg   <= 1'b0;
         ferr_reg  <= 1'b0;
         pstb_reg  <= 1'b0;
      end else begin
         state_reg <= state_next;
         tick_reg  <= tick_next;
         count_reg <= count_next;
         shift_reg <= shift_next;
         perr_reg  <= perr_next;
         data_reg  <= data_next;
         vld_reg   <= vld_next;
         ferr_reg  <= ferr_next;
         pstb_reg  <= pstb_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      tick_next  = UART_CLK_EN ? tick_reg + 4'd1 : tick_reg;
      count_next = count_reg;
      shift_next = shift_reg;
      perr_next  = perr_reg;
      data_next  = data_reg;
      vld_next   = 1'b0;
      ferr_next  = 1'b0;
      pstb_next  = 1'b0;

      case (state_reg)
         IDLE: begin
            tick_next  = 4'd0;
            count_next = 3'd0;
            perr_next  = 1'b0;
            if (fall_edge) state_next = START;
         end
         START: begin
            if (mid_tick) state_next = sample ? IDLE : DATA;
         end
         DATA: begin
            if (mid_tick) begin
               shift_next[count_reg] = sample;
               count_next            = count_reg + 3'd1;
               if (count_reg == 3'(DATA_BITS - 1))
                  state_next = PAR_EN ? PARITY : STOP;
            end
         end
         PARITY: begin
            if (mid_tick) begin
               perr_next  = sample != (PAR_ODD ? ~^shift_reg : ^shift_reg);
               state_next = STOP;
            end
         end
         STOP: begin
            // Rearm at mid-stop so the next start edge can arrive up to half a bit early.
            if (mid_tick) begin
               state_next = IDLE;
               if (!sample) begin
                  ferr_next = 1'b1;
               end else if (perr_reg) begin
                  pstb_next = 1'b1;
               end else begin
                  data_next = shift_reg;
                  vld_next  = 1'b1;
               end
            end
         end
         default: begin
            state_next = IDLE;
            tick_next  = 4'd0;
         end
      endcase
   end

   assign DATA_OUT     = data_reg;
   assign DATA_VLD     = vld_reg;
   assign FRAME_ERROR  = ferr_reg;
   assign PARITY_ERROR = pstb_reg;
   assign STATE        = state_reg;
   assign BUSY         = (state_reg == START) || (state_reg == DATA) ||
                         (state_reg == PARITY) || (state_reg == STOP);

endmodule
